craft_state_register: RTL and testbench



---
 rtl/craft_pkg.sv | 30 +++
 rtl/craft_state_register_if.sv | 27 ++
 rtl/craft_permute_nibbles.sv | 17 +
 rtl/craft_state_register.sv | 59 +++++
 tb/tb_craft_state_register.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/craft_pkg.sv
// craft_pkg: shared constants for the CRAFT datapath.
// Holds nibble/state geometry, the state-register mode encodings and the
// PermuteNibbles table. Used by craft_state_register (whose optional
// permute mode is enabled by CRAFT_STATE_PERM_EN) and craft_permute_nibbles.
package craft_pkg;

    localparam int NIB_W   = 4;
    localparam int STATE_W = 64;
    localparam int NUM_NIB = 16;

    // Mode select as seen on {CS1, CS0}.
    typedef enum logic [1:0] {
        MODE_ROTATE   = 2'b00,
        MODE_LOAD     = 2'b01,
        MODE_PERMUTE  = 2'b10,
        MODE_SHIFT_IN = 2'b11
    } mode_t;

    // PermuteNibbles table P packed nibble-first: P[0] sits in bits [63:60].
    // new[i] = old[P[i]]; P is an involution.
    localparam logic [STATE_W-1:0] PERM_TABLE = 64'hFCDE_A98B_6547_1230;

    // Source nibble index for destination nibble i.
    function automatic int perm_idx(input int i);
        logic [STATE_W-1:0] tbl;
        tbl = PERM_TABLE;
        return int'(tbl[STATE_W-1-NIB_W*i -: NIB_W]);
    endfunction

endpackage

// File: rtl/craft_state_register_if.sv
// craft_state_register_if: controller <-> state register bundle.
// There is no valid/ready pair here: the controller asserts ce for every
// cycle it wants an update and the register acts on that edge
// unconditionally (always ready, one-cycle latency); ce=0 is a hold.
interface craft_state_register_if;
    import craft_pkg::*;

    logic                 ce;
    logic [STATE_W-1:0]   plaintext;
    logic [NIB_W-1:0]     in;
    logic                 CS0;
    logic                 CS1;
    logic [NIB_W-1:0]     out;
    // Full register contents, exposed for observation and checking.
    logic [STATE_W-1:0]   state;

    modport master (
        output ce, plaintext, in, CS0, CS1,
        input  out, state
    );

    modport slave (
        input  ce, plaintext, in, CS0, CS1,
        output out, state
    );

endinterface

// File: rtl/craft_permute_nibbles.sv
// craft_permute_nibbles: combinational CRAFT PermuteNibbles on a 64-bit
// state, new[i] = old[P[i]]. Pure wiring; reusable by key-schedule and
// decryption paths.
module craft_permute_nibbles
    import craft_pkg::*;
(
    input  logic [STATE_W-1:0] din,
    output logic [STATE_W-1:0] dout
);

    for (genvar i = 0; i < NUM_NIB; i++) begin : g_nib
        localparam int SRC = perm_idx(i);
        // Route source nibble P[i] to destination nibble i.
        assign dout[STATE_W-1-NIB_W*i -: NIB_W] = din[STATE_W-1-NIB_W*SRC -: NIB_W];
    end

endmodule

// File: rtl/craft_state_register.sv
// craft_state_register: nibble-serial 64-bit CRAFT state register.
// Modes on {CS1,CS0} when ce=1: rotate, parallel load, shift-in, and
// (only with CRAFT_STATE_PERM_EN defined) single-cycle PermuteNibbles.
// Without the macro, mode 10 holds and no permutation logic exists.
// out is nibble 0 taken straight from the register.
module craft_state_register
    import craft_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    craft_state_register_if.slave bus
);

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    mode_t              mode;

    assign mode = mode_t'({bus.CS1, bus.CS0});

`ifdef CRAFT_STATE_PERM_EN
    logic [STATE_W-1:0] perm_out;

    craft_permute_nibbles u_perm (
        .din  (state_q),
        .dout (perm_out)
    );
`endif

    // Next-state selection; ce=0 or an unsupported mode holds.
    always_comb begin
        state_d = state_q;
        if (bus.ce) begin
            case (mode)
                MODE_ROTATE:   state_d = {state_q[STATE_W-NIB_W-1:0], state_q[STATE_W-1 -: NIB_W]};
                MODE_LOAD:     state_d = bus.plaintext;
                MODE_SHIFT_IN: state_d = {state_q[STATE_W-NIB_W-1:0], bus.in};
`ifdef CRAFT_STATE_PERM_EN
                MODE_PERMUTE:  state_d = perm_out;
`else
                MODE_PERMUTE:  state_d = state_q;
`endif
                default:       state_d = state_q;
            endcase
        end
    end

    // State register with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    assign bus.out   = state_q[STATE_W-1 -: NIB_W];
    assign bus.state = state_q;

endmodule

// File: tb/tb_craft_state_register.sv
// tb_craft_state_register: directed test of craft_state_register.
// Expected values are hand-computed constants. Mode 10 expectations follow
// CRAFT_STATE_PERM_EN, so the bench works in both builds.
module tb_craft_state_register;
    import craft_pkg::*;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    craft_state_register_if bus ();

    craft_state_register dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Clock: 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One rising edge, then settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_mode(input logic ce, input logic [1:0] m);
        bus.ce  = ce;
        bus.CS1 = m[1];
        bus.CS0 = m[0];
    endtask

    initial begin
        logic [3:0] shift_vals [4];
        total = 0;
        bad   = 0;
        shift_vals = '{4'h4, 4'h8, 4'hC, 4'h0};

        rst_n         = 1'b0;
        bus.ce        = 1'b0;
        bus.CS0       = 1'b0;
        bus.CS1       = 1'b0;
        bus.in        = 4'h0;
        bus.plaintext = 64'h0;

        // Reset state.
        #2;
        check64("reset_state", bus.state, 64'h0);
        check4("reset_out", bus.out, 4'h0);

        // Load.
        bus.plaintext = 64'h0123_4567_89AB_CDEF;
        set_mode(1'b1, 2'b01);
        #1 rst_n = 1'b1;
        tick();
        check64("load_state", bus.state, 64'h0123_4567_89AB_CDEF);
        check4("load_out", bus.out, 4'h0);

        // Rotate 4 with in don't-care.
        bus.plaintext = 64'hDEAD_BEEF_DEAD_BEEF;
        set_mode(1'b1, 2'b00);
        bus.in = 4'bx;
        tick();
        check4("rot1_out", bus.out, 4'h1);
        tick();
        tick();
        tick();
        check64("rot4_state", bus.state, 64'h4567_89AB_CDEF_0123);
        check4("rot4_out", bus.out, 4'h4);

        // Further 12 rotations restore alignment, then rotate back to 4.
        for (int i = 0; i < 12; i++) tick();
        check64("rot16_state", bus.state, 64'h0123_4567_89AB_CDEF);
        for (int i = 0; i < 4; i++) tick();
        check64("rot20_state", bus.state, 64'h4567_89AB_CDEF_0123);

        // Shift-in 4, 8, C, 0.
        set_mode(1'b1, 2'b11);
        for (int i = 0; i < 4; i++) begin
            bus.in = shift_vals[i];
            tick();
        end
        check64("shift_state", bus.state, 64'h89AB_CDEF_0123_48C0);
        check4("shift_out", bus.out, 4'h8);

        // Hold with ce=0 under several modes.
        bus.in = 4'hF;
        set_mode(1'b0, 2'b00);
        tick();
        check64("hold_rot", bus.state, 64'h89AB_CDEF_0123_48C0);
        set_mode(1'b0, 2'b01);
        tick();
        check64("hold_load", bus.state, 64'h89AB_CDEF_0123_48C0);
        set_mode(1'b0, 2'b11);
        tick();
        check64("hold_shift", bus.state, 64'h89AB_CDEF_0123_48C0);
        check4("hold_out", bus.out, 4'h8);

        // Mode 10.
        set_mode(1'b1, 2'b10);
        tick();
`ifdef CRAFT_STATE_PERM_EN
        check64("perm_a_state", bus.state, 64'h048C_2103_EDCF_9AB8);
        check4("perm_a_out", bus.out, 4'h0);
        tick();
        check64("perm_twice", bus.state, 64'h89AB_CDEF_0123_48C0);
        bus.plaintext = 64'h0123_4567_89AB_CDEF;
        set_mode(1'b1, 2'b01);
        tick();
        set_mode(1'b1, 2'b10);
        tick();
        check64("perm_b_state", bus.state, 64'hFCDE_A98B_6547_1230);
        check4("perm_b_out", bus.out, 4'hF);
        tick();
        check64("perm_b_twice", bus.state, 64'h0123_4567_89AB_CDEF);
`else
        check64("mode10_hold", bus.state, 64'h89AB_CDEF_0123_48C0);
        check4("mode10_out", bus.out, 4'h8);
        bus.plaintext = 64'h0123_4567_89AB_CDEF;
        set_mode(1'b1, 2'b01);
        tick();
        set_mode(1'b1, 2'b10);
        tick();
        check64("mode10_hold_b", bus.state, 64'h0123_4567_89AB_CDEF);
`endif

        // Back-to-back mode changes: load, rotate, shift-in.
        bus.plaintext = 64'hFEDC_BA98_7654_3210;
        set_mode(1'b1, 2'b01);
        tick();
        set_mode(1'b1, 2'b00);
        tick();
        check64("b2b_rot", bus.state, 64'hEDCB_A987_6543_210F);
        set_mode(1'b1, 2'b11);
        bus.in = 4'h5;
        tick();
        check64("b2b_shift", bus.state, 64'hDCBA_9876_5432_10F5);
        check4("b2b_out", bus.out, 4'hD);

        // Asynchronous reset between edges mid-rotate.
        set_mode(1'b1, 2'b00);
        tick();
        tick();
        #3 rst_n = 1'b0;
        #1;
        check64("async_rst_state", bus.state, 64'h0);
        check4("async_rst_out", bus.out, 4'h0);
        tick();
        check64("rst_held_state", bus.state, 64'h0);

        // Load after release.
        bus.plaintext = 64'h1357_9BDF_0246_8ACE;
        set_mode(1'b1, 2'b01);
        #2 rst_n = 1'b1;
        tick();
        check64("post_rst_load", bus.state, 64'h1357_9BDF_0246_8ACE);
        check4("post_rst_out", bus.out, 4'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
